spi_slave_param: RTL

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parameterised SPI slave, SCLK-clocked, any CPOL/CPHA
//
// Ports:
//   SCLK      in   serial clock, the only clock of the block
//   reset     in   asynchronous active-high reset
//   CS        in   active-low chip select
//   MOSI      in   serial data from master
//   tx_data   in   [WIDTH] word sent in the next frame (captured on bit-0 sample edge)
//   MISO      out  serial data to master (0 whenever miso_oe is low)
//   miso_oe   out  MISO drive enable (CS low and reset low)
//   rx_data   out  [WIDTH] last completely received word
//   rx_toggle out  inverts once per completed frame
//   frame_err out  sticky: an aborted frame was detected
module spi_slave_param #(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 1
) (
    input  logic             SCLK,
    input  logic             reset,
    input  logic             CS,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] tx_data,
    output logic             MISO,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_toggle,
    output logic             frame_err
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    // Sample edge is SCLK rising when CPOL==CPHA, falling otherwise; fold
    // that into one internal clock whose rising edge is always the sample edge.
    localparam logic            INV  = (CPOL != CPHA);

    logic             sample_clk;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_sr_q, rx_word_d;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_toggle_q;
    logic             frame_err_q;
    logic             mid_frame_q;
    logic             sel_q;
    logic             out_q;
    logic             first_bit;
    logic             tx_head;

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    assign sample_clk = SCLK ^ INV;

    always_comb begin
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        rx_word_d = (LSB_FIRST != 0) ? {MOSI, rx_sr_q[WIDTH-1:1]}
                                     : {rx_sr_q[WIDTH-2:0], MOSI};
        first_bit = (LSB_FIRST != 0) ? tx_data[0] : tx_data[WIDTH-1];
        tx_head   = (LSB_FIRST != 0) ? tx_q[0]    : tx_q[WIDTH-1];
    end

    // Bit position and TX shifter: both restart whenever CS is released.
    // On the bit-0 sample edge tx_data is captured already advanced by one,
    // so the head of tx_q is always the next bit to launch.
    always_ff @(posedge sample_clk or posedge reset or posedge CS) begin
        if (reset || CS) begin
            cnt_q <= '0;
            tx_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            tx_q  <= (cnt_q == '0) ? shift_out(tx_data) : shift_out(tx_q);
        end
    end

    // Receive side and error tracking; these survive CS deassertion.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_toggle_q <= 1'b0;
            frame_err_q <= 1'b0;
            mid_frame_q <= 1'b0;
        end else if (!CS) begin
            rx_sr_q     <= rx_word_d;
            mid_frame_q <= (cnt_d != '0);
            if (cnt_q == LAST) begin
                rx_data_q   <= rx_word_d;
                rx_toggle_q <= ~rx_toggle_q;
            end
            // A new frame starting while the previous one never completed.
            if (cnt_q == '0 && mid_frame_q)
                frame_err_q <= 1'b1;
        end
    end

    // Launch side: once bit 0 has been sampled, MISO comes from out_q; after
    // the final sample the counter is back at 0 and MISO returns to tx_data.
    always_ff @(negedge sample_clk or posedge reset or posedge CS) begin
        if (reset || CS) begin
            sel_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            sel_q <= (cnt_q != '0);
            out_q <= tx_head;
        end
    end

    assign miso_oe   = ~CS & ~reset;
    assign MISO      = miso_oe & (sel_q ? out_q : first_bit);
    assign rx_data   = rx_data_q;
    assign rx_toggle = rx_toggle_q;
    assign frame_err = frame_err_q;

endmodule
